// File: rtl/ula_pkg.sv
// Shared types for the shift/flag stage: default width, shift-op encoding, payload word.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package ula_pkg;

  localparam int WIDTH_DEF = 32;
  // Widest legal datapath; the payload struct is sized to it so one type serves every WIDTH.
  localparam int WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    SLL8    = 2'd1,
    SRA1    = 2'd2,
    ILLEGAL = 2'd3
  } shift_op_e;

  // c holds the shifted result in its low WIDTH bits; bits above WIDTH stay zero.
  typedef struct packed {
    logic [WIDTH_MAX-1:0] c;
    logic                 n;
    logic                 z;
    logic                 cout;
  } payload_t;

  function automatic shift_op_e decode_op(input logic sll8, input logic sra1);
    case ({sra1, sll8})
      2'b01:   return SLL8;
      2'b10:   return SRA1;
      2'b11:   return ILLEGAL;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/shift_nz_stage_if.sv
// Bundle of the stage's upstream (ALU word in) and downstream (C-bus word out) signals.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
interface shift_nz_stage_if
  import ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             sll8;
  logic             sra1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c_bus;
  logic             n_flag;
  logic             z_flag;
  logic             cout_q;
  logic             op_err;

  // master: the environment around the stage (ALU side driving, C-bus side consuming).
  modport master (
    output in_valid, alu_res, alu_cout, sll8, sra1, out_ready,
    input  in_ready, out_valid, c_bus, n_flag, z_flag, cout_q, op_err
  );

  // slave: the stage itself.
  modport slave (
    input  in_valid, alu_res, alu_cout, sll8, sra1, out_ready,
    output in_ready, out_valid, c_bus, n_flag, z_flag, cout_q, op_err
  );
endinterface

// File: rtl/shifter_w.sv
// Combinational shifter: pass, shift-left-logical by 8, or shift-right-arithmetic by 1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: op (decoded shift op), din (ALU result), dout (shifted result).
module shifter_w
  import ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  shift_op_e        op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      SLL8:    dout = {din[WIDTH-9:0], 8'b0};
      SRA1:    dout = {din[WIDTH-1], din[WIDTH-1:1]};
      // ILLEGAL deliberately passes the word through; the stage flags it separately.
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_nz_stage.sv
// Shift/flag stage: shifts the ALU word, derives N/Z/carry, buffers in a 2-entry skid pipeline.
// Latency: 1 cycle from accept to out_valid when the output register is free or draining.
// Backpressure: in_ready is a registered !skid_full, so it never depends combinationally on out_ready.
// Ports: clk, rst_n (async, active-low), io (slave modport: in_* upstream, out_*/c_bus/flags downstream, op_err).
module shift_nz_stage
  import ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_nz_stage_if.slave io
);

  shift_op_e        shift_op;
  logic [WIDTH-1:0] shifted;
  payload_t         new_pl;

  payload_t out_q,      out_d;
  logic     out_vld_q,  out_vld_d;
  payload_t skid_q,     skid_d;
  logic     skid_vld_q, skid_vld_d;
  logic     in_rdy_q,   in_rdy_d;
  logic     op_err_q,   op_err_d;

  logic accept;
  logic out_free;

  assign shift_op = decode_op(io.sll8, io.sra1);

  shifter_w #(.WIDTH(WIDTH)) u_shifter (
    .op   (shift_op),
    .din  (io.alu_res),
    .dout (shifted)
  );

  // Flags come from the unshifted ALU word.
  always_comb begin
    new_pl              = '0;
    new_pl.c[WIDTH-1:0] = shifted;
    new_pl.n            = io.alu_res[WIDTH-1];
    new_pl.z            = (io.alu_res == '0);
    new_pl.cout         = io.alu_cout;
  end

  assign accept   = io.in_valid & in_rdy_q;
  // Output register can take a word this cycle: empty, or its word leaves this cycle.
  assign out_free = ~out_vld_q | io.out_ready;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (out_free) begin
      if (skid_vld_q) begin
        // Older skid word goes first; a same-cycle accept (not possible while the
        // skid is full, as in_ready is low) would refill the skid.
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = new_pl;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = new_pl;
      end
    end else if (accept) begin
      skid_d     = new_pl;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = ~skid_vld_d;
    op_err_d = accept & (shift_op == ILLEGAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
      op_err_q   <= op_err_d;
    end
  end

  assign io.in_ready  = in_rdy_q;
  assign io.out_valid = out_vld_q;
  assign io.c_bus     = out_q.c[WIDTH-1:0];
  assign io.n_flag    = out_q.n;
  assign io.z_flag    = out_q.z;
  assign io.cout_q    = out_q.cout;
  assign io.op_err    = op_err_q;

  // Payload bits above WIDTH are constant zero and never reach a port.
  logic unused_pad;
  assign unused_pad = ^{out_q.c, skid_q.c};

endmodule

// File: tb/tb_shift_nz_stage.sv
module tb_shift_nz_stage;
  import ula_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_nz_stage_if #(.WIDTH(32)) bus ();

  shift_nz_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {c, n, z, cout} for a 32-bit word.
  function automatic logic [34:0] model(input logic [31:0] a, input logic s8,
                                        input logic s1, input logic co);
    logic [31:0] c;
    if (s8 && !s1)      c = a << 8;
    else if (s1 && !s8) c = 32'($signed(a) >>> 1);
    else                c = a;
    return {c, a[31], (a == 32'd0), co};
  endfunction

  function automatic logic [34:0] observed();
    return {bus.c_bus, bus.n_flag, bus.z_flag, bus.cout_q};
  endfunction

  initial begin
    logic [34:0] q[$];
    logic [34:0] exp_w;
    int sent;
    int cyc;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_res   = '0;
    bus.alu_cout  = 1'b0;
    bus.sll8      = 1'b0;
    bus.sra1      = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_c_bus",     bus.c_bus, 0);
    chk("rst_flags",     {bus.n_flag, bus.z_flag, bus.cout_q}, 0);
    chk("rst_op_err",    bus.op_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // SRA1 on a negative word
    bus.in_valid = 1'b1; bus.alu_res = 32'h8000_0001; bus.sra1 = 1'b1; bus.sll8 = 1'b0;
    bus.alu_cout = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("sra1_valid", bus.out_valid, 1);
    chk("sra1_c_bus", bus.c_bus, 32'hC000_0000);
    chk("sra1_n",     bus.n_flag, 1);
    chk("sra1_z",     bus.z_flag, 0);
    chk("sra1_op_err", bus.op_err, 0);

    // SLL8 of zero with carry: back-to-back with the previous word
    bus.alu_res = 32'h0; bus.sll8 = 1'b1; bus.sra1 = 1'b0; bus.alu_cout = 1'b1;
    tick();
    chk("zero_valid", bus.out_valid, 1);
    chk("zero_c_bus", bus.c_bus, 0);
    chk("zero_nzc",   {bus.n_flag, bus.z_flag, bus.cout_q}, 3'b011);

    // SLL8 of a negative word: N from unshifted input
    bus.alu_res = 32'hFF00_00AB; bus.alu_cout = 1'b0;
    tick();
    chk("sll8_c_bus", bus.c_bus, 32'h0000_AB00);
    chk("sll8_nzc",   {bus.n_flag, bus.z_flag, bus.cout_q}, 3'b100);

    // Illegal code: pass-through plus op_err pulse
    bus.alu_res = 32'h1234_5678; bus.sll8 = 1'b1; bus.sra1 = 1'b1;
    tick();
    chk("illegal_c_bus",  bus.c_bus, 32'h1234_5678);
    chk("illegal_op_err", bus.op_err, 1);
    bus.in_valid = 1'b0; bus.sll8 = 1'b0; bus.sra1 = 1'b0;
    tick();
    chk("illegal_op_err_end", bus.op_err, 0);
    chk("drained_valid",      bus.out_valid, 0);

    // Backpressure: fill both entries, hold, then drain in order
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.alu_res = 32'h11;
    tick();
    chk("bp_first_valid", bus.out_valid, 1);
    chk("bp_first_c_bus", bus.c_bus, 32'h11);
    chk("bp_first_ready", bus.in_ready, 1);
    bus.alu_res = 32'h22;
    tick();
    chk("bp_full_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_c_bus", bus.c_bus, 32'h11);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_second_c_bus", bus.c_bus, 32'h22);
    chk("bp_second_valid", bus.out_valid, 1);
    chk("bp_ready_back",   bus.in_ready, 1);
    tick();
    chk("bp_empty_valid", bus.out_valid, 0);

    // Random traffic against the reference model
    sent = 0;
    cyc  = 0;
    while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
      bus.in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      bus.alu_res   = $urandom();
      if ($urandom_range(0, 7) == 0) bus.alu_res = 32'h0;
      bus.sll8      = 1'($urandom_range(0, 1));
      bus.sra1      = 1'($urandom_range(0, 1));
      bus.alu_cout  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.alu_res, bus.sll8, bus.sra1, bus.alu_cout));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("rand_extra_word", 1, 0);
        end else begin
          exp_w = q.pop_front();
          chk("rand_word", observed(), exp_w);
        end
      end
      tick();
      cyc++;
    end
    chk("rand_all_sent",      sent, 10000);
    chk("rand_all_delivered", q.size(), 0);

    // Reset with both entries full: nothing old may appear afterwards
    bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.sll8 = 1'b0; bus.sra1 = 1'b0;
    bus.alu_res = 32'hAA;
    tick();
    bus.alu_res = 32'hBB;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_rst_full", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_c_bus", bus.c_bus, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("after_rst_no_old", bus.out_valid, 0);
    end
    chk("after_rst_ready", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
